register_file: RTL and testbench

- General-purpose register file for the CPU core datapath.
- 64 entries of 32 bits, with two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (operand fetch) and writeback.

---
 rtl/register_file.sv | 39 +++
 tb/tb_register_file.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register file: 2**ADDR_WIDTH x DATA_WIDTH entries, two
// combinational read ports, one synchronous write port, entry 0 reads as zero.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Read1,
    input  logic [ADDR_WIDTH-1:0] Read2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a simultaneous write; address 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (RegWrite && (WriteReg != '0)) begin
            mem[WriteReg] <= WriteData;
        end
    end

    // No bypass: a write becomes visible only after the edge that stores it.
    always_comb begin
        Data1 = (Read1 == '0) ? '0 : mem[Read1];
        Data2 = (Read2 == '0) ? '0 : mem[Read2];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed plan steps followed by a
// randomized phase checked against an array-based reference model.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Read1, Read2, WriteReg;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] Data1, Data2;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .Read1    (Read1),
        .Read2    (Read2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .Data1    (Data1),
        .Data2    (Data2)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [N];
    int passed = 0;
    int total  = 0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Apply the spec's update rule to the model, then let the DUT see the edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < N; i++) model[i] = '0;
        end else if (RegWrite && WriteReg != 0) begin
            model[WriteReg] = WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        Read1 = a1;
        Read2 = a2;
        #1;
        check({tag, "_d1"}, Data1, model_rd(a1));
        check({tag, "_d2"}, Data2, model_rd(a2));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        RegWrite = 1'b1; WriteReg = a; WriteData = d;
        tick();
        RegWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b0; Read1 = '0; Read2 = '0; WriteReg = '0; WriteData = '0; RegWrite = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 'x;
        @(negedge clk);

        // 1. reset, then sweep every address
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            Read1 = AW'(i); Read2 = AW'(N - 1 - i);
            #1;
            check("reset_d1", Data1, 32'd0);
            check("reset_d2", Data2, 32'd0);
        end

        // 2. basic writes, stray data never written
        wr(6'd1, 32'd32);
        wr(6'd5, 32'd21);
        WriteData = 32'd10; WriteReg = 6'd1;
        Read1 = 6'd1; Read2 = 6'd5; #1;
        check("basic_r1", Data1, 32'd32);
        check("basic_r5", Data2, 32'd21);
        for (int k = 0; k < 4; k++) tick();
        check("hold_r1", Data1, 32'd32);
        check("hold_r5", Data2, 32'd21);

        // 3. overwrite
        wr(6'd1, 32'd200);
        check("over_r1", Data1, 32'd200);
        check("over_r5", Data2, 32'd21);

        // 4. zero register
        wr(6'd0, 32'd128);
        Read1 = 6'd0; Read2 = 6'd5; #1;
        check("zero_r0", Data1, 32'd0);
        check("zero_r5", Data2, 32'd21);

        // 5. same-cycle read of the write target
        wr(6'd7, 32'd5);
        Read1 = 6'd7; Read2 = 6'd7;
        RegWrite = 1'b1; WriteReg = 6'd7; WriteData = 32'd9; #1;
        check("pre_edge_d1", Data1, 32'd5);
        check("pre_edge_d2", Data2, 32'd5);
        tick();
        check("post_edge_d1", Data1, 32'd9);
        check("same_port", Data2, Data1);
        RegWrite = 1'b0;

        // 6. reset during a pending write
        wr(6'd63, 32'hFFFF_FFFF);
        rd("r63", 6'd63, 6'd2);
        check("r63_lit", Data1, 32'hFFFF_FFFF);
        RegWrite = 1'b1; WriteReg = 6'd2; WriteData = 32'hA5A5_A5A5; rst = 1'b1;
        tick();
        rst = 1'b0; RegWrite = 1'b0;
        Read1 = 6'd63; Read2 = 6'd2; #1;
        check("rst_r63", Data1, 32'd0);
        check("rst_r2", Data2, 32'd0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            RegWrite  = ($urandom_range(0, 3) != 0);
            WriteReg  = AW'($urandom_range(0, N - 1));
            WriteData = $urandom;
            rst       = ($urandom_range(0, 79) == 0);
            rd("rand_pre", AW'($urandom_range(0, N - 1)), ($urandom_range(0, 3) == 0) ? WriteReg : AW'($urandom_range(0, N - 1)));
            tick();
            rst = 1'b0;
            rd("rand_post", WriteReg, AW'($urandom_range(0, N - 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
